mips_sequencer: RTL and testbench

//  Multi-cycle control FSM that sequences the mips datapath: PC, instruction memory, IR, register file, ALU.

---
 rtl/mips_pkg.sv | 31 +++
 rtl/mips_sequencer_if.sv | 38 +++
 rtl/mips_op_decode.sv | 41 ++++
 rtl/mips_sequencer.sv | 154 +++++++++++++++
 tb/tb_mips_sequencer.sv | 377 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared opcode/ALU encodings and the sequencer state type.
// No logic, no latency.
// No flow control.
package mips_pkg;

  // Opcode field IR[5:0]
  localparam logic [5:0] OP_NOP  = 6'h00;
  localparam logic [5:0] OP_ADD  = 6'h01;
  localparam logic [5:0] OP_SUB  = 6'h02;
  localparam logic [5:0] OP_AND  = 6'h03;
  localparam logic [5:0] OP_OR   = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h05;
  localparam logic [5:0] OP_BEQ  = 6'h06;
  localparam logic [5:0] OP_HALT = 6'h3F;

  // ALU operation codes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    WB,
    HALTED
  } state_t;

endpackage

// File: rtl/mips_sequencer_if.sv
// Control/status bundle between the sequencer and the mips datapath.
// No logic, no latency.
// Fetch uses a req/ack handshake; every other signal is a plain level.
interface mips_sequencer_if #(
  parameter int CNT_W = 32
);
  logic             start;
  logic             mem_ack;
  logic [5:0]       op;
  logic             alu_zero;
  logic             mem_req;
  logic             ir_we;
  logic             pc_we;
  logic             pc_src;
  logic             rf_we;
  logic [2:0]       alu_ctrl;
  logic             rb_sel;
  logic             imm_sel;
  logic             busy;
  logic             halted;
  logic             illegal;
  logic             bus_err;
  logic [CNT_W-1:0] instr_count;

  // Sequencer side
  modport master (
    input  start, mem_ack, op, alu_zero,
    output mem_req, ir_we, pc_we, pc_src, rf_we, alu_ctrl, rb_sel, imm_sel,
           busy, halted, illegal, bus_err, instr_count
  );

  // Datapath / environment side
  modport slave (
    output start, mem_ack, op, alu_zero,
    input  mem_req, ir_we, pc_we, pc_src, rf_we, alu_ctrl, rb_sel, imm_sel,
           busy, halted, illegal, bus_err, instr_count
  );
endinterface

// File: rtl/mips_op_decode.sv
// Opcode to control-field decoder.
// Purely combinational, zero latency.
// No flow control.
module mips_op_decode
  import mips_pkg::*;
(
  input  logic [5:0] op,
  output logic [2:0] alu_ctrl,
  output logic       imm_sel,
  output logic       rb_sel,
  output logic       is_branch,
  output logic       writes_rf,
  output logic       is_nop,
  output logic       is_halt,
  output logic       is_illegal
);

  // Table lookup; anything not listed is flagged illegal
  always_comb begin
    alu_ctrl   = ALU_AND;
    imm_sel    = 1'b0;
    rb_sel     = 1'b0;
    is_branch  = 1'b0;
    writes_rf  = 1'b0;
    is_nop     = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    case (op)
      OP_NOP:  is_nop = 1'b1;
      OP_ADD:  begin alu_ctrl = ALU_ADD; writes_rf = 1'b1; end
      OP_SUB:  begin alu_ctrl = ALU_SUB; writes_rf = 1'b1; end
      OP_AND:  begin alu_ctrl = ALU_AND; writes_rf = 1'b1; end
      OP_OR:   begin alu_ctrl = ALU_OR;  writes_rf = 1'b1; end
      OP_ADDI: begin alu_ctrl = ALU_ADD; writes_rf = 1'b1; imm_sel = 1'b1; end
      OP_BEQ:  begin alu_ctrl = ALU_SUB; rb_sel = 1'b1; is_branch = 1'b1; end
      OP_HALT: is_halt = 1'b1;
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/WB control FSM for the mips datapath.
// Zero-wait fetch: ALU op 4 cycles, BEQ 3, NOP 2.
// Fetch stalls on mem_ack; no ack within MEM_TIMEOUT request cycles halts with bus_err.
module mips_sequencer
  import mips_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  mips_sequencer_if.master  bus
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [2:0]        alu_ctrl_q;
  logic              rb_sel_q;
  logic              imm_sel_q;
  logic              branch_q;
  logic              writes_rf_q;
  logic              rf_we_q;
  logic              illegal_q;
  logic              bus_err_q;
  logic [CNT_W-1:0]  count_q;

  logic [2:0] dec_alu_ctrl;
  logic       dec_imm_sel;
  logic       dec_rb_sel;
  logic       dec_is_branch;
  logic       dec_writes_rf;
  logic       dec_is_nop;
  logic       dec_is_halt;
  logic       dec_is_illegal;
  logic       branch_taken;

  // Decodes the live IR opcode; used only while in DECODE
  mips_op_decode u_dec (
    .op         (bus.op),
    .alu_ctrl   (dec_alu_ctrl),
    .imm_sel    (dec_imm_sel),
    .rb_sel     (dec_rb_sel),
    .is_branch  (dec_is_branch),
    .writes_rf  (dec_writes_rf),
    .is_nop     (dec_is_nop),
    .is_halt    (dec_is_halt),
    .is_illegal (dec_is_illegal)
  );

  // Sequencer state, latched controls, sticky status and retire counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      alu_ctrl_q  <= '0;
      rb_sel_q    <= 1'b0;
      imm_sel_q   <= 1'b0;
      branch_q    <= 1'b0;
      writes_rf_q <= 1'b0;
      rf_we_q     <= 1'b0;
      illegal_q   <= 1'b0;
      bus_err_q   <= 1'b0;
      count_q     <= '0;
    end else begin
      // Defaults: wait counter is cleared in every non-FETCH state, so each
      // FETCH starts from zero; the write strobe lives exactly one cycle
      wait_cnt <= '0;
      rf_we_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) state <= FETCH;
        end
        FETCH: begin
          // Ack is checked first so an ack on the last allowed cycle wins
          if (bus.mem_ack) begin
            state <= DECODE;
          end else if (wait_cnt == WAIT_LAST) begin
            bus_err_q <= 1'b1;
            state     <= HALTED;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        DECODE: begin
          if (dec_is_illegal) begin
            illegal_q <= 1'b1;
            state     <= HALTED;
          end else if (dec_is_halt) begin
            state <= HALTED;
          end else if (dec_is_nop) begin
            count_q <= count_q + CNT_W'(1);
            state   <= FETCH;
          end else begin
            // Latch the decoded fields; EXEC/WB never look at the live IR
            alu_ctrl_q  <= dec_alu_ctrl;
            rb_sel_q    <= dec_rb_sel;
            imm_sel_q   <= dec_imm_sel;
            branch_q    <= dec_is_branch;
            writes_rf_q <= dec_writes_rf;
            state       <= EXEC;
          end
        end
        EXEC: begin
          if (writes_rf_q) begin
            rf_we_q <= 1'b1;
            state   <= WB;
          end else begin
            count_q     <= count_q + CNT_W'(1);
            alu_ctrl_q  <= '0;
            rb_sel_q    <= 1'b0;
            imm_sel_q   <= 1'b0;
            branch_q    <= 1'b0;
            writes_rf_q <= 1'b0;
            state       <= FETCH;
          end
        end
        WB: begin
          count_q     <= count_q + CNT_W'(1);
          alu_ctrl_q  <= '0;
          rb_sel_q    <= 1'b0;
          imm_sel_q   <= 1'b0;
          branch_q    <= 1'b0;
          writes_rf_q <= 1'b0;
          state       <= FETCH;
        end
        HALTED: begin
          state <= HALTED;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The datapath loads IR/PC on the edge that ends the ack cycle, so these
  // strobes must track mem_ack/alu_zero within the cycle; mem_req does not
  assign branch_taken    = (state == EXEC) && branch_q && bus.alu_zero;
  assign bus.mem_req     = (state == FETCH);
  assign bus.ir_we       = (state == FETCH) && bus.mem_ack;
  assign bus.pc_we       = bus.ir_we || branch_taken;
  assign bus.pc_src      = branch_taken;
  assign bus.rf_we       = rf_we_q;
  assign bus.alu_ctrl    = alu_ctrl_q;
  assign bus.rb_sel      = rb_sel_q;
  assign bus.imm_sel     = imm_sel_q;
  assign bus.busy        = (state != IDLE) && (state != HALTED);
  assign bus.halted      = (state == HALTED);
  assign bus.illegal     = illegal_q;
  assign bus.bus_err     = bus_err_q;
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_mips_sequencer.sv
// Self-checking bench: programs of opcodes are replayed through an emulated
// IR/instruction memory and compared against a cycle-cost reference model.
// A second instance with a 4-bit counter shares all inputs to exercise wrap.
module tb_mips_sequencer;
  import mips_pkg::*;

  localparam int TMO    = 15;
  localparam int BUDGET = 3000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mips_sequencer_if #(.CNT_W(32)) bus ();
  mips_sequencer_if #(.CNT_W(4))  bus4 ();

  mips_sequencer #(.CNT_W(32), .MEM_TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  mips_sequencer #(.CNT_W(4), .MEM_TIMEOUT(TMO)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  assign bus4.start    = bus.start;
  assign bus4.mem_ack  = bus.mem_ack;
  assign bus4.op       = bus.op;
  assign bus4.alu_zero = bus.alu_zero;

  int total = 0;
  int bad   = 0;

  // Program under test: opcode, alu_zero during its execution, ack wait
  logic [5:0] p_op[$];
  bit         p_zero[$];
  int         p_wait[$];

  // Reference-model expectations
  int     exp_rf[$];
  int     exp_br[$];
  int     exp_halt, exp_fetch, exp_req;
  longint exp_count;
  bit     exp_ill, exp_berr;

  // Observations
  int act_rf[$];
  int act_br[$];
  int cyc, idx, wait_ctr, act_fetch, act_req;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_alu(logic [5:0] o);
    return (o == OP_ADD) || (o == OP_SUB) || (o == OP_AND) || (o == OP_OR) || (o == OP_ADDI);
  endfunction

  function automatic bit is_legal(logic [5:0] o);
    return is_alu(o) || (o == OP_NOP) || (o == OP_BEQ) || (o == OP_HALT);
  endfunction

  // Expected {alu_ctrl, imm_sel, rb_sel} while an instruction executes
  function automatic logic [4:0] exp_ctrl(logic [5:0] o);
    case (o)
      OP_ADD:  return {ALU_ADD, 1'b0, 1'b0};
      OP_SUB:  return {ALU_SUB, 1'b0, 1'b0};
      OP_AND:  return {ALU_AND, 1'b0, 1'b0};
      OP_OR:   return {ALU_OR,  1'b0, 1'b0};
      OP_ADDI: return {ALU_ADD, 1'b1, 1'b0};
      OP_BEQ:  return {ALU_SUB, 1'b0, 1'b1};
      default: return 5'h1f;
    endcase
  endfunction

  task automatic push(logic [5:0] o, bit z, int w);
    p_op.push_back(o);
    p_zero.push_back(z);
    p_wait.push_back(w);
  endtask

  task automatic clear_prog();
    p_op.delete();
    p_zero.delete();
    p_wait.delete();
  endtask

  // Cycle-cost model. Cycle 1 is the first cycle after the edge that
  // samples start. A fetch costs wait+1 cycles; then NOP/HALT/illegal
  // cost 1 (decode), BEQ 2 (decode, exec), ALU ops 3 (decode, exec, wb).
  task automatic model();
    int c;
    c = 0;
    exp_rf.delete();
    exp_br.delete();
    exp_fetch = 0;
    exp_req   = 0;
    exp_count = 0;
    exp_ill   = 1'b0;
    exp_berr  = 1'b0;
    for (int i = 0; i < p_op.size(); i++) begin
      if (p_wait[i] >= TMO) begin
        c += TMO;
        exp_req += TMO;
        exp_berr = 1'b1;
        break;
      end
      c += p_wait[i] + 1;
      exp_req += p_wait[i] + 1;
      exp_fetch++;
      if (p_op[i] == OP_NOP) begin
        c += 1;
        exp_count++;
      end else if (p_op[i] == OP_HALT) begin
        c += 1;
        break;
      end else if (is_alu(p_op[i])) begin
        c += 3;
        exp_rf.push_back(c);
        exp_count++;
      end else if (p_op[i] == OP_BEQ) begin
        c += 2;
        if (p_zero[i]) exp_br.push_back(c);
        exp_count++;
      end else begin
        c += 1;
        exp_ill = 1'b1;
        break;
      end
    end
    exp_halt = c + 1;
  endtask

  task automatic check_zero(string tag);
    check({tag, "_outs"}, {bus.mem_req, bus.ir_we, bus.pc_we, bus.pc_src, bus.rf_we,
                           bus.alu_ctrl, bus.rb_sel, bus.imm_sel, bus.busy, bus.halted,
                           bus.illegal, bus.bus_err}, 64'd0);
    check({tag, "_cnt"}, bus.instr_count, 64'd0);
    check({tag, "_cnt4"}, bus4.instr_count, 64'd0);
  endtask

  task automatic do_reset(string tag, bit ack);
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.mem_ack  = ack;
    bus.alu_zero = 1'b0;
    @(posedge clk);
    #1;
    check_zero(tag);
    rst_n       = 1'b1;
    bus.mem_ack = 1'b0;
  endtask

  // One cycle of emulated memory + IR, with per-cycle observation
  task automatic tick();
    bit s_ir;
    if (bus.mem_req) begin
      act_req++;
      if (idx < p_op.size())
        bus.mem_ack = (p_wait[idx] < TMO) && (wait_ctr == p_wait[idx]);
      else
        bus.mem_ack = 1'b0;
      wait_ctr++;
    end else begin
      bus.mem_ack = 1'b0;
    end
    #1;
    s_ir = bus.ir_we;
    if (bus.ir_we) begin
      act_fetch++;
      check($sformatf("fetch_pc_c%0d", cyc), {bus.pc_we, bus.pc_src}, 64'd2);
    end
    if (bus.rf_we) begin
      act_rf.push_back(cyc);
      check($sformatf("wb_ctrl_c%0d", cyc), {bus.alu_ctrl, bus.imm_sel, bus.rb_sel},
            exp_ctrl(bus.op));
    end
    if (bus.pc_src) begin
      act_br.push_back(cyc);
      check($sformatf("br_ctrl_c%0d", cyc), {bus.pc_we, bus.alu_ctrl, bus.imm_sel, bus.rb_sel},
            {1'b1, ALU_SUB, 1'b0, 1'b1});
    end
    @(posedge clk);
    if (s_ir) begin
      bus.op       = p_op[idx];
      bus.alu_zero = p_zero[idx];
      idx++;
      wait_ctr = 0;
    end
    #1;
    cyc++;
  endtask

  task automatic start_prog(string tag);
    model();
    act_rf.delete();
    act_br.delete();
    idx       = 0;
    wait_ctr  = 0;
    act_fetch = 0;
    act_req   = 0;
    do_reset({tag, "_rst"}, 1'b0);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    cyc = 1;
    check({tag, "_busy"}, bus.busy, 64'd1);
  endtask

  task automatic finish_prog(string tag);
    while (!bus.halted && cyc < BUDGET) tick();
    bus.mem_ack = 1'b0;
    check({tag, "_halted"}, bus.halted, 64'd1);
    check({tag, "_halt_cyc"}, cyc, exp_halt);
    check({tag, "_rf_n"}, act_rf.size(), exp_rf.size());
    for (int i = 0; i < exp_rf.size() && i < act_rf.size(); i++)
      check($sformatf("%s_rf%0d", tag, i), act_rf[i], exp_rf[i]);
    check({tag, "_br_n"}, act_br.size(), exp_br.size());
    for (int i = 0; i < exp_br.size() && i < act_br.size(); i++)
      check($sformatf("%s_br%0d", tag, i), act_br[i], exp_br[i]);
    check({tag, "_fetch"}, act_fetch, exp_fetch);
    check({tag, "_req"}, act_req, exp_req);
    check({tag, "_cnt"}, bus.instr_count, exp_count);
    check({tag, "_cnt4"}, bus4.instr_count, exp_count % 16);
    check({tag, "_ill"}, bus.illegal, exp_ill);
    check({tag, "_berr"}, bus.bus_err, exp_berr);
    check({tag, "_busy_end"}, bus.busy, 64'd0);
  endtask

  task automatic gen_random();
    int n;
    logic [5:0] o;
    clear_prog();
    n = $urandom_range(3, 10);
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 6))
        0: o = OP_NOP;
        1: o = OP_ADD;
        2: o = OP_SUB;
        3: o = OP_AND;
        4: o = OP_OR;
        5: o = OP_ADDI;
        default: o = OP_BEQ;
      endcase
      push(o, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TMO - 1)) : int'($urandom_range(0, 1)));
    end
    case ($urandom_range(0, 2))
      0: push(OP_HALT, 1'b0, $urandom_range(0, 2));
      1: begin
        o = 6'($urandom_range(0, 63));
        for (int k = 0; k < 64 && is_legal(o); k++) o = 6'($urandom_range(0, 63));
        if (is_legal(o)) o = 6'h2A;
        push(o, 1'b0, 0);
      end
      default: push(OP_HALT, 1'b0, TMO);
    endcase
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.mem_ack  = 1'b0;
    bus.op       = OP_NOP;
    bus.alu_zero = 1'b0;

    // Reset state
    do_reset("init", 1'b0);
    @(posedge clk);
    #1;
    check("idle_no_start", {bus.mem_req, bus.busy}, 64'd0);

    // ADD, SUB, ADDI, HALT with immediate acks: rf_we in cycles 4/8/12;
    // HALT decodes in cycle 14, so halted is first seen in cycle 15
    clear_prog();
    push(OP_ADD, 0, 0); push(OP_SUB, 0, 0); push(OP_ADDI, 0, 0); push(OP_HALT, 0, 0);
    start_prog("t1");
    finish_prog("t1");
    check("t1_rf_a", (act_rf.size() > 0) ? act_rf[0] : -1, 64'd4);
    check("t1_rf_b", (act_rf.size() > 1) ? act_rf[1] : -1, 64'd8);
    check("t1_rf_c", (act_rf.size() > 2) ? act_rf[2] : -1, 64'd12);
    check("t1_halt15", cyc, 64'd15);
    check("t1_cnt3", bus.instr_count, 64'd3);

    // BEQ taken / not taken
    clear_prog();
    push(OP_BEQ, 1, 0); push(OP_HALT, 0, 0);
    start_prog("t2a");
    finish_prog("t2a");
    check("t2a_br_cyc3", (act_br.size() > 0) ? act_br[0] : -1, 64'd3);
    clear_prog();
    push(OP_BEQ, 0, 0); push(OP_HALT, 0, 0);
    start_prog("t2b");
    finish_prog("t2b");

    // Fetch timeout, and ack on the last allowed cycle
    clear_prog();
    push(OP_ADD, 0, TMO);
    start_prog("t3a");
    finish_prog("t3a");
    check("t3a_req15", act_req, 64'd15);
    clear_prog();
    push(OP_ADD, 0, TMO - 1); push(OP_HALT, 0, 0);
    start_prog("t3b");
    finish_prog("t3b");

    // Illegal opcode; start ignored afterwards
    clear_prog();
    push(6'h2A, 0, 0);
    start_prog("t4");
    finish_prog("t4");
    repeat (4) begin
      bus.start = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    check("t4_sticky", {bus.halted, bus.illegal, bus.mem_req, bus.busy, bus.rf_we}, 64'b11000);
    check("t4_cnt", bus.instr_count, 64'd0);

    // Reset in the middle of a fetch, with ack presented during reset
    clear_prog();
    push(OP_NOP, 0, 0); push(OP_NOP, 0, 2); push(OP_ADD, 0, 0); push(OP_HALT, 0, 0);
    start_prog("t5a");
    while (!(bus.mem_req && bus.instr_count == 1) && cyc < BUDGET) tick();
    check("t5a_in_fetch", {bus.mem_req, bus.instr_count}, {1'b1, 32'd1});
    do_reset("t5a_mid", 1'b1);
    bus.mem_ack = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_ack = 1'b0;
    check("t5a_idle", {bus.mem_req, bus.busy, bus.ir_we}, 64'd0);
    clear_prog();
    push(OP_NOP, 0, 1); push(OP_OR, 0, 0); push(OP_HALT, 0, 0);
    start_prog("t5a_re");
    finish_prog("t5a_re");

    // Reset during write-back
    clear_prog();
    push(OP_ADD, 0, 0); push(OP_AND, 0, 0); push(OP_HALT, 0, 0);
    start_prog("t5b");
    while (!(bus.rf_we && bus.instr_count == 1) && cyc < BUDGET) tick();
    check("t5b_in_wb", {bus.rf_we, bus.instr_count}, {1'b1, 32'd1});
    do_reset("t5b_mid", 1'b0);
    clear_prog();
    push(OP_SUB, 0, 0); push(OP_HALT, 0, 0);
    start_prog("t5b_re");
    finish_prog("t5b_re");

    // 17 NOPs: 4-bit counter wraps to 1
    clear_prog();
    for (int i = 0; i < 17; i++) push(OP_NOP, 0, 0);
    push(OP_HALT, 0, 0);
    start_prog("t6");
    finish_prog("t6");
    check("t6_cnt4_wrap", bus4.instr_count, 64'd1);
    check("t6_cnt32", bus.instr_count, 64'd17);

    // Random programs
    for (int r = 0; r < 12; r++) begin
      gen_random();
      start_prog($sformatf("rnd%0d", r));
      finish_prog($sformatf("rnd%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
